clk_phase_track: RTL and testbench

- Single-clock phase tracker for the fast side of an integer-ratio SDR-to-fast clock crossing.
- Samples a toggle signal produced once per slow-clock period (slow-domain TFF output, already aligned to the fast clock).
- Derives the fast-cycle phase index 0..RATIO-1 within each slow period, with first/last strobes.
- Qualifies the relationship with a lock state machine and reports phase errors.
- Successor to the fixed 2:1 clock follower: generalised ratio, phase index, lock/error detection.

---
 rtl/clk_phase_track.sv | 174 +++++++++++++++++
 tb/tb_clk_phase_track.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_phase_track.sv
// clk_phase_track: fast-side phase tracker for an integer-ratio slow-to-fast
// clock crossing. A slow-domain toggle (already aligned to clk_i) marks each
// slow period. The fast cycle in which it changes is phase 0. The block
// reports the phase of every fast cycle, qualifies the relationship with a
// lock state machine, and counts phase errors seen while locked.
//
// Ports:
//   clk_i      fast clock, rising edge
//   rst_i      synchronous reset, active-high
//   tog_i      slow-domain toggle, inverts once per slow period
//   clr_err_i  synchronous clear of err_cnt_o
//   phase_o    phase of the previous fast cycle, 0..RATIO-1
//   first_o    previous cycle was phase 0 (toggle edge seen)
//   last_o     phase_o == RATIO-1
//   locked_o   state machine is LOCKED
//   err_o      one-cycle pulse on a phase mismatch while LOCKED
//   err_cnt_o  saturating mismatch count
module clk_phase_track #(
  parameter int unsigned RATIO    = 2,
  parameter int unsigned LOCK_CNT = 4,
  localparam int unsigned PHASE_W = $clog2(RATIO)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tog_i,
  input  logic               clr_err_i,
  output logic [PHASE_W-1:0] phase_o,
  output logic               first_o,
  output logic               last_o,
  output logic               locked_o,
  output logic               err_o,
  output logic [7:0]         err_cnt_o
);

  localparam int unsigned MC_W = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ACQUIRE  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(RATIO - 1);
  localparam logic [MC_W-1:0]    MC_LOCK = MC_W'(LOCK_CNT);

  logic               tog_q;
  logic [PHASE_W-1:0] ph_q, ph_d;
  logic [1:0]         state_q, state_d;
  logic [MC_W-1:0]    mcnt_q, mcnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic [7:0]         ecnt_q, ecnt_d;

  logic               tog_edge;
  logic               expected;
  logic               mismatch;
  logic               realign;
  logic [7:0]         ecnt_base;

  // Next-state, phase prediction and output decode
  always_comb begin
    state_d   = state_q;
    mcnt_d    = mcnt_q;
    err_d     = 1'b0;
    realign   = 1'b0;
    ecnt_base = ecnt_q;
    ecnt_d    = ecnt_q;

    tog_edge = tog_i ^ tog_q;
    expected = (ph_q == '0);
    mismatch = tog_edge ^ expected;

    case (state_q)
      ST_UNLOCKED: begin
        if (tog_edge) begin
          state_d = ST_ACQUIRE;
          mcnt_d  = MC_W'(1);
          realign = 1'b1;
        end
      end
      ST_ACQUIRE: begin
        if (tog_edge && expected) begin
          // mcnt_q < LOCK_CNT here, so the increment cannot overflow
          mcnt_d  = mcnt_q + MC_W'(1);
          realign = 1'b1;
          if (mcnt_q + MC_W'(1) == MC_LOCK) begin
            state_d = ST_LOCKED;
          end
        end else if (tog_edge) begin
          mcnt_d  = MC_W'(1);
          realign = 1'b1;
        end else if (expected) begin
          mcnt_d = '0;
        end
      end
      ST_LOCKED: begin
        // Freewheel; only an early edge is allowed to move the phase
        if (mismatch) begin
          state_d = ST_ACQUIRE;
          err_d   = 1'b1;
          if (tog_edge) begin
            mcnt_d  = MC_W'(1);
            realign = 1'b1;
          end else begin
            mcnt_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
        mcnt_d  = '0;
      end
    endcase

    // Clear applies first so a coincident mismatch still counts
    if (clr_err_i) begin
      ecnt_base = '0;
    end
    if (err_d && (ecnt_base != 8'hFF)) begin
      ecnt_d = ecnt_base + 8'd1;
    end else begin
      ecnt_d = ecnt_base;
    end

    if (tog_edge && realign) begin
      ph_d = PHASE_W'(1);
    end else if (ph_q == PH_LAST) begin
      ph_d = '0;
    end else begin
      ph_d = ph_q + PHASE_W'(1);
    end

    phase_d  = tog_edge ? '0 : ph_q;
    first_d  = tog_edge;
    last_d   = (phase_d == PH_LAST);
    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tog_q    <= 1'b0;
      ph_q     <= '0;
      state_q  <= ST_UNLOCKED;
      mcnt_q   <= '0;
      phase_q  <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      tog_q    <= tog_i;
      ph_q     <= ph_d;
      state_q  <= state_d;
      mcnt_q   <= mcnt_d;
      phase_q  <= phase_d;
      first_q  <= first_d;
      last_q   <= last_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign phase_o   = phase_q;
  assign first_o   = first_q;
  assign last_o    = last_q;
  assign locked_o  = locked_q;
  assign err_o     = err_q;
  assign err_cnt_o = ecnt_q;

endmodule

// File: tb/tb_clk_phase_track.sv
// Testbench for clk_phase_track: four instances (RATIO 2, 3, 4, 5, LOCK_CNT 4)
// share one clock. Expected outputs are queued when inputs are driven and
// compared one cycle later when the registered outputs appear.
module tb_clk_phase_track;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_v, tog_v, clr_v;
  logic [0:0] ph0;
  logic [1:0] ph1, ph2;
  logic [2:0] ph3;
  logic [3:0] first_w, last_w, locked_w, err_w;
  logic [7:0] ec0, ec1, ec2, ec3;

  clk_phase_track #(.RATIO(2), .LOCK_CNT(4)) u_r2 (
    .clk_i(clk), .rst_i(rst_v[0]), .tog_i(tog_v[0]), .clr_err_i(clr_v[0]),
    .phase_o(ph0), .first_o(first_w[0]), .last_o(last_w[0]),
    .locked_o(locked_w[0]), .err_o(err_w[0]), .err_cnt_o(ec0));

  clk_phase_track #(.RATIO(3), .LOCK_CNT(4)) u_r3 (
    .clk_i(clk), .rst_i(rst_v[1]), .tog_i(tog_v[1]), .clr_err_i(clr_v[1]),
    .phase_o(ph1), .first_o(first_w[1]), .last_o(last_w[1]),
    .locked_o(locked_w[1]), .err_o(err_w[1]), .err_cnt_o(ec1));

  clk_phase_track #(.RATIO(4), .LOCK_CNT(4)) u_r4 (
    .clk_i(clk), .rst_i(rst_v[2]), .tog_i(tog_v[2]), .clr_err_i(clr_v[2]),
    .phase_o(ph2), .first_o(first_w[2]), .last_o(last_w[2]),
    .locked_o(locked_w[2]), .err_o(err_w[2]), .err_cnt_o(ec2));

  clk_phase_track #(.RATIO(5), .LOCK_CNT(4)) u_r5 (
    .clk_i(clk), .rst_i(rst_v[3]), .tog_i(tog_v[3]), .clr_err_i(clr_v[3]),
    .phase_o(ph3), .first_o(first_w[3]), .last_o(last_w[3]),
    .locked_o(locked_w[3]), .err_o(err_w[3]), .err_cnt_o(ec3));

  // Table record: inputs for one cycle and the outputs they must produce
  typedef struct {
    int   d;
    logic rst;
    logic tog;
    int   ph, fi, la, lk, er, ec;
  } vec_t;

  // Scoreboard record; a negative expected value means "don't care"
  typedef struct {
    int    due;
    int    d;
    string name;
    int    ph, fi, la, lk, er, ec;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc_n = 0;

  function automatic vec_t mk(int d, logic rst, logic tog, int ph, int fi,
                              int la, int lk);
    vec_t v;
    v.d = d; v.rst = rst; v.tog = tog;
    v.ph = ph; v.fi = fi; v.la = la; v.lk = lk; v.er = 0; v.ec = 0;
    return v;
  endfunction

  function automatic int act(int d, int f);
    int r;
    r = 0;
    case (f)
      0: case (d)
           0: r = int'(ph0);
           1: r = int'(ph1);
           2: r = int'(ph2);
           default: r = int'(ph3);
         endcase
      1: r = int'(first_w[d]);
      2: r = int'(last_w[d]);
      3: r = int'(locked_w[d]);
      4: r = int'(err_w[d]);
      default: case (d)
           0: r = int'(ec0);
           1: r = int'(ec1);
           2: r = int'(ec2);
           default: r = int'(ec3);
         endcase
    endcase
    return r;
  endfunction

  task automatic cmp(string name, string fld, int a, int e);
    if (e < 0) return;
    n_vec++;
    if (a != e) begin
      n_miss++;
      $display("FAIL %s.%s: got %0d, expected %0d (cycle %0d)", name, fld, a, e, cyc_n);
    end
  endtask

  task automatic check_due();
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc_n) begin
      e = exp_q.pop_front();
      cmp(e.name, "phase_o",   act(e.d, 0), e.ph);
      cmp(e.name, "first_o",   act(e.d, 1), e.fi);
      cmp(e.name, "last_o",    act(e.d, 2), e.la);
      cmp(e.name, "locked_o",  act(e.d, 3), e.lk);
      cmp(e.name, "err_o",     act(e.d, 4), e.er);
      cmp(e.name, "err_cnt_o", act(e.d, 5), e.ec);
    end
  endtask

  task automatic expect_o(int d, string name, int ph, int fi, int la, int lk,
                          int er, int ec);
    exp_t e;
    e.due = cyc_n + 1; e.d = d; e.name = name;
    e.ph = ph; e.fi = fi; e.la = la; e.lk = lk; e.er = er; e.ec = ec;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    check_due();
  endtask

  task automatic flip(int d);
    tog_v[d] = ~tog_v[d];
  endtask

  task automatic hold(int n);
    repeat (n) step();
  endtask

  // Regular toggling: an edge every `ratio` cycles starting on the first
  task automatic run(int d, int ratio, int n);
    for (int c = 0; c < n; c++) begin
      if (c % ratio == 0) flip(d);
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_v = '1;
    tog_v = '0;
    clr_v = '0;
    @(negedge clk);
    step();
    step();
    rst_v = '0;

    // RATIO=2: edge every 2 cycles, phase alternates 0,1, lock on 4th edge
    vecs.push_back(mk(0, 1'b1, 1'b0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1'b0, 1'b1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1'b0, 1'b1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1'b0, 1'b0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1'b0, 1'b0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1'b0, 1'b1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1'b0, 1'b1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1'b0, 1'b0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1'b0, 1'b0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1'b0, 1'b1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1'b0, 1'b1, 1, 0, 1, 1));
    // RATIO=3: toggles at cycles 0,3,6,9; locked_o rises after the edge at 9
    vecs.push_back(mk(1, 1'b1, 1'b0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1'b0, 1'b1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1'b0, 1'b1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1'b0, 1'b1, 2, 0, 1, 0));
    vecs.push_back(mk(1, 1'b0, 1'b0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1'b0, 1'b0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1'b0, 1'b0, 2, 0, 1, 0));
    vecs.push_back(mk(1, 1'b0, 1'b1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1'b0, 1'b1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1'b0, 1'b1, 2, 0, 1, 0));
    vecs.push_back(mk(1, 1'b0, 1'b0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 1'b0, 1'b0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1'b0, 1'b0, 2, 0, 1, 1));
    vecs.push_back(mk(1, 1'b0, 1'b1, 0, 1, 0, 1));
    vecs.push_back(mk(1, 1'b0, 1'b1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1'b0, 1'b1, 2, 0, 1, 1));

    foreach (vecs[i]) begin
      rst_v[vecs[i].d] = vecs[i].rst;
      tog_v[vecs[i].d] = vecs[i].tog;
      expect_o(vecs[i].d, $sformatf("tbl[%0d]", i), vecs[i].ph, vecs[i].fi,
               vecs[i].la, vecs[i].lk, vecs[i].er, vecs[i].ec);
      step();
    end

    // RATIO=4: lock, then a missing edge, relock, then reset mid-lock
    rst_v[2] = 1'b1;
    expect_o(2, "r4_reset", 0, 0, 0, 0, 0, 0); step();
    rst_v[2] = 1'b0;
    run(2, 4, 16);
    flip(2); expect_o(2, "r4_locked", 0, 1, 0, 1, 0, 0); step();
    hold(2);
    expect_o(2, "r4_last", 3, 0, 1, 1, 0, 0); step();
    expect_o(2, "r4_missing", 0, 0, 0, 0, 1, 1); step();
    expect_o(2, "r4_err_once", 1, 0, 0, 0, 0, 1); step();
    hold(2);
    run(2, 4, 11);
    expect_o(2, "r4_prelock", 3, 0, 1, 0, 0, 1); step();
    flip(2); expect_o(2, "r4_relock", 0, 1, 0, 1, 0, 1); step();
    expect_o(2, "r4_pre_rst", 1, 0, 0, 1, 0, 1); step();
    rst_v[2] = 1'b1;
    expect_o(2, "r4_rst_mid", 0, 0, 0, 0, 0, 0); step();
    rst_v[2] = 1'b0;
    // tog_i is 1 here; against the reset value of tog_q that is an edge
    expect_o(2, "r4_rst_edge", 0, 1, 0, 0, 0, 0); step();
    hold(3);
    run(2, 4, 8);
    flip(2); expect_o(2, "r4_relock2", 0, 1, 0, 1, 0, 0); step();

    // RATIO=5: lock, early edge, relock through the non-power-of-2 wrap
    rst_v[3] = 1'b1;
    expect_o(3, "r5_reset", 0, 0, 0, 0, 0, 0); step();
    rst_v[3] = 1'b0;
    run(3, 5, 20);
    flip(3); expect_o(3, "r5_locked", 0, 1, 0, 1, 0, 0); step();
    hold(2);
    flip(3); expect_o(3, "r5_early", 0, 1, 0, 0, 1, 1); step();
    hold(4);
    flip(3); expect_o(3, "r5_acq", 0, 1, 0, 0, 0, 1); step();
    hold(4);
    flip(3); step();
    hold(3);
    expect_o(3, "r5_wrap", 4, 0, 1, 0, 0, 1); step();
    flip(3); expect_o(3, "r5_relock", 0, 1, 0, 1, 0, 1); step();
    hold(2);

    // 300 early-edge mismatches while locked; the count must stop at 255
    for (int k = 0; k < 300; k++) begin
      flip(3);
      expect_o(3, $sformatf("sat[%0d]", k), -1, -1, -1, 0, 1,
               (k + 2 > 255) ? 255 : k + 2);
      step();
      hold(4); flip(3); step();
      hold(4); flip(3); step();
      hold(4); flip(3); step();
      hold(2);
    end

    clr_v[3] = 1'b1;
    expect_o(3, "clr_alone", 3, 0, 0, 1, 0, 0); step();
    clr_v[3] = 1'b0;
    expect_o(3, "clr_hold", 4, 0, 1, 1, 0, 0); step();
    clr_v[3] = 1'b1;
    expect_o(3, "clr_with_miss", 0, 0, 0, 0, 1, 1); step();
    clr_v[3] = 1'b0;
    expect_o(3, "err_cnt_kept", -1, -1, -1, 0, 0, 1); step();

    // Static toggle after reset: never leaves UNLOCKED
    tog_v[1] = 1'b0;
    rst_v[1] = 1'b1;
    expect_o(1, "static_reset", 0, 0, 0, 0, 0, 0); step();
    rst_v[1] = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (i % 100 == 99) expect_o(1, $sformatf("static[%0d]", i), -1, 0, -1, 0, 0, 0);
      step();
    end

    step();
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
